// File: rtl/counter_seq.sv
// counter_seq: programmable start/end/step counter with prescaler, pause,
// one-shot or auto-reload sequencing, and a status readback byte.
//
// Ports
//   clk      : clock, all state on rising edge
//   rst_n    : asynchronous active-low reset
//   ena      : design enable; all registers hold while low
//   ui_in    : [0] cfg_we  [2:1] cfg_sel (00 start, 01 end, 10 step, 11 prescale)
//              [3] go (rising edge)  [4] halt  [5] mode (1 = auto-reload)
//              [6] dir (1 = down)    [7] out_sel (1 = status byte)
//   uio_in   : configuration write data
//   uo_out   : count, or {state, done_flag, reload_cnt} when out_sel=1
//   uio_out  : constant 0
//   uio_oe   : constant 0 (uio used as input only)
module counter_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_END   = 2'd1;
  localparam logic [1:0] SEL_STEP  = 2'd2;
  localparam logic [1:0] SEL_PRE   = 2'd3;

  // control decode
  logic       w_cfg_we, w_go_lvl, w_halt, w_mode, w_dir, w_out_sel;
  logic [1:0] w_cfg_sel;
  assign w_cfg_we  = ui_in[0];
  assign w_cfg_sel = ui_in[2:1];
  assign w_go_lvl  = ui_in[3];
  assign w_halt    = ui_in[4];
  assign w_mode    = ui_in[5];
  assign w_dir     = ui_in[6];
  assign w_out_sel = ui_in[7];

  // state
  logic [2:0] r_state;
  logic [7:0] r_count, r_pc;
  logic [7:0] r_start, r_end, r_step, r_pre;
  logic       r_done;
  logic [3:0] r_reload;
  logic       r_go_prev;
  // r_go_arm is cleared by reset and set once go has been seen low, so a go
  // level held high across reset release cannot masquerade as a fresh edge.
  logic       r_go_arm;

  logic       w_go;
  logic [7:0] w_eff_step, w_dist, w_next_count;
  logic       w_last;

  assign w_go         = w_go_lvl & ~r_go_prev & r_go_arm;
  assign w_eff_step   = (r_step == 8'd0) ? 8'd1 : r_step;
  // distance remaining toward end in the current direction, modulo 256
  assign w_dist       = w_dir ? (r_count - r_end) : (r_end - r_count);
  assign w_last       = (w_dist <= w_eff_step);
  assign w_next_count = w_dir ? (r_count - w_eff_step) : (r_count + w_eff_step);

  // configuration registers, writable in any state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_start <= 8'h00;
      r_end   <= 8'hFF;
      r_step  <= 8'h01;
      r_pre   <= 8'h00;
    end else if (ena && w_cfg_we) begin
      case (w_cfg_sel)
        SEL_START: r_start <= uio_in;
        SEL_END:   r_end   <= uio_in;
        SEL_STEP:  r_step  <= uio_in;
        SEL_PRE:   r_pre   <= uio_in;
        default:   r_pre   <= uio_in;
      endcase
    end
  end

  // go edge tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_go_prev <= 1'b0;
      r_go_arm  <= 1'b0;
    end else if (ena) begin
      r_go_prev <= w_go_lvl;
      if (!w_go_lvl) r_go_arm <= 1'b1;
    end
  end

  // sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_count  <= 8'h00;
      r_pc     <= 8'h00;
      r_done   <= 1'b0;
      r_reload <= 4'h0;
    end else if (ena) begin
      case (r_state)
        S_IDLE: begin
          if (w_go) begin
            r_state <= S_LOAD;
            r_done  <= 1'b0;
          end
        end
        S_LOAD: begin
          r_count <= r_start;
          r_pc    <= 8'h00;
          if (r_start == r_end) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_halt) begin
            r_state <= S_PAUSE;
          end else if (r_pc == r_pre) begin
            r_pc <= 8'h00;
            if (w_last) begin
              r_count <= r_end;
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_count <= w_next_count;
            end
          end else begin
            r_pc <= r_pc + 8'd1;
          end
        end
        S_PAUSE: begin
          if (!w_halt) r_state <= S_RUN;
        end
        S_DONE: begin
          r_done <= 1'b1;
          // an explicit go restarts cleanly; otherwise auto-reload loops
          if (w_go) begin
            r_state <= S_LOAD;
            r_done  <= 1'b0;
          end else if (w_mode) begin
            r_reload <= r_reload + 4'd1;
            r_state  <= S_LOAD;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uo_out  = w_out_sel ? {r_state, r_done, r_reload} : r_count;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule
